// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: tracks in-flight fetch predictions in a FIFO, resolves them at execute,
// issues flush/redirect on mispredict and trains the predictor. Optional statistics: BRU_STATS_EN.
module branch_resolve_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  PredValidF,
  input  logic [DATA_WIDTH-1:0] PredPCF,
  input  logic [DATA_WIDTH-1:0] PredTargetF,
  input  logic                  PredDirF,
  input  logic                  PredTakenF,
  input  logic                  BranchE,
  input  logic                  ZeroE,
  output logic                  flushBranch,
  output logic [DATA_WIDTH-1:0] PCRedirect,
  output logic                  PCRedirectSrc,
  output logic                  UpdateValid,
  output logic                  UpdateDir,
  output logic                  UpdateTaken,
  output logic                  QueueFull,
  output logic                  OrphanErr,
  output logic [15:0]           BranchCount,
  output logic [15:0]           MispredCount
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {TRACK, FLUSH} state_t;

  state_t state, state_nx;

  logic [DATA_WIDTH-1:0] pc_q  [DEPTH];
  logic [DATA_WIDTH-1:0] tgt_q [DEPTH];
  logic [DEPTH-1:0]      dir_q;
  logic [DEPTH-1:0]      tkn_q;

  logic [PW-1:0] rptr, wptr;
  logic [CW-1:0] count;

  logic pop, push, mispred;
  logic [DATA_WIDTH-1:0] redirect_nx;

  assign pop       = BranchE && (count != '0);
  assign mispred   = pop && (tkn_q[rptr] != ZeroE);
  // A mispredict kills the whole queue, so a same-cycle push must not land.
  assign push      = PredValidF && (state == TRACK) && ((count != FULL_CNT) || pop) && !mispred;
  assign QueueFull = (count == FULL_CNT);
  assign redirect_nx = ZeroE ? tgt_q[rptr] : pc_q[rptr] + DATA_WIDTH'(4);

  always_comb begin
    state_nx = state;
    case (state)
      TRACK:   if (mispred) state_nx = FLUSH;
      FLUSH:   state_nx = TRACK;
      default: state_nx = TRACK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= TRACK;
    else        state <= state_nx;
  end

  // Entry storage carries no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wptr]  <= PredPCF;
      tgt_q[wptr] <= PredTargetF;
      dir_q[wptr] <= PredDirF;
      tkn_q[wptr] <= PredTakenF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (mispred) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flushBranch   <= 1'b0;
      PCRedirectSrc <= 1'b0;
      PCRedirect    <= '0;
      UpdateValid   <= 1'b0;
      UpdateDir     <= 1'b0;
      UpdateTaken   <= 1'b0;
      OrphanErr     <= 1'b0;
    end else begin
      flushBranch   <= mispred;
      PCRedirectSrc <= mispred;
      UpdateValid   <= pop;
      if (mispred) PCRedirect <= redirect_nx;
      if (pop) begin
        UpdateDir   <= dir_q[rptr];
        UpdateTaken <= ZeroE;
      end
      if (BranchE && (count == '0)) OrphanErr <= 1'b1;
    end
  end

`ifdef BRU_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      BranchCount  <= '0;
      MispredCount <= '0;
    end else begin
      if (pop && (BranchCount != '1))      BranchCount  <= BranchCount + 1'b1;
      if (mispred && (MispredCount != '1)) MispredCount <= MispredCount + 1'b1;
    end
  end
`else
  assign BranchCount  = '0;
  assign MispredCount = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Table-driven bench for branch_resolve_unit with a queue of expected per-cycle outputs,
// plus hand sequences for asynchronous reset during flush and with a part-filled queue.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        PredValidF = 1'b0;
  logic [31:0] PredPCF = '0;
  logic [31:0] PredTargetF = '0;
  logic        PredDirF = 1'b0;
  logic        PredTakenF = 1'b0;
  logic        BranchE = 1'b0;
  logic        ZeroE = 1'b0;
  logic        flushBranch;
  logic [31:0] PCRedirect;
  logic        PCRedirectSrc;
  logic        UpdateValid, UpdateDir, UpdateTaken;
  logic        QueueFull, OrphanErr;
  logic [15:0] BranchCount, MispredCount;

  branch_resolve_unit #(.DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .PredValidF(PredValidF), .PredPCF(PredPCF), .PredTargetF(PredTargetF),
    .PredDirF(PredDirF), .PredTakenF(PredTakenF),
    .BranchE(BranchE), .ZeroE(ZeroE),
    .flushBranch(flushBranch), .PCRedirect(PCRedirect), .PCRedirectSrc(PCRedirectSrc),
    .UpdateValid(UpdateValid), .UpdateDir(UpdateDir), .UpdateTaken(UpdateTaken),
    .QueueFull(QueueFull), .OrphanErr(OrphanErr),
    .BranchCount(BranchCount), .MispredCount(MispredCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic [31:0] pc, tgt;
    logic        dir, tkn, be, z;
    logic        ef;
    logic [31:0] er;
    logic        eu, ed, et, eq, eo;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned exp_bc = 0;
  int unsigned exp_mc = 0;

  function automatic vec_t mk(logic pv, logic [31:0] pc, logic [31:0] tgt, logic dir, logic tkn,
                              logic be, logic z, logic ef, logic [31:0] er, logic eu,
                              logic ed, logic et, logic eq, logic eo);
    vec_t v;
    v.pv = pv; v.pc = pc; v.tgt = tgt; v.dir = dir; v.tkn = tkn; v.be = be; v.z = z;
    v.ef = ef; v.er = er; v.eu = eu; v.ed = ed; v.et = et; v.eq = eq; v.eo = eo;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_out(vec_t e, int unsigned idx);
    string t;
    t = $sformatf("v%0d", idx);
    chk({t, ".flushBranch"}, 32'(flushBranch), 32'(e.ef));
    chk({t, ".PCRedirectSrc"}, 32'(PCRedirectSrc), 32'(e.ef));
    chk({t, ".UpdateValid"}, 32'(UpdateValid), 32'(e.eu));
    chk({t, ".QueueFull"}, 32'(QueueFull), 32'(e.eq));
    chk({t, ".OrphanErr"}, 32'(OrphanErr), 32'(e.eo));
    if (e.ef) chk({t, ".PCRedirect"}, PCRedirect, e.er);
    if (e.eu) begin
      chk({t, ".UpdateDir"}, 32'(UpdateDir), 32'(e.ed));
      chk({t, ".UpdateTaken"}, 32'(UpdateTaken), 32'(e.et));
    end
  endtask

  task automatic chk_zero(string t);
    chk({t, ".flushBranch"}, 32'(flushBranch), 0);
    chk({t, ".PCRedirectSrc"}, 32'(PCRedirectSrc), 0);
    chk({t, ".PCRedirect"}, PCRedirect, 0);
    chk({t, ".UpdateValid"}, 32'(UpdateValid), 0);
    chk({t, ".UpdateDir"}, 32'(UpdateDir), 0);
    chk({t, ".UpdateTaken"}, 32'(UpdateTaken), 0);
    chk({t, ".QueueFull"}, 32'(QueueFull), 0);
    chk({t, ".OrphanErr"}, 32'(OrphanErr), 0);
    chk({t, ".BranchCount"}, 32'(BranchCount), 0);
    chk({t, ".MispredCount"}, 32'(MispredCount), 0);
  endtask

  task automatic apply(vec_t v, int unsigned idx);
    vec_t e;
    @(negedge clk);
    PredValidF = v.pv; PredPCF = v.pc; PredTargetF = v.tgt;
    PredDirF = v.dir; PredTakenF = v.tkn; BranchE = v.be; ZeroE = v.z;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk_out(e, idx);
  endtask

  task automatic pulse_reset(string t);
    rst_n = 1'b0;
    #1;
    chk_zero(t);
    @(negedge clk);
    PredValidF = 1'b0; BranchE = 1'b0; ZeroE = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    //             pv pc        tgt       d  tk be z   ef er        eu ed et eq eo
    tbl.push_back(mk(1, 32'h100, 32'h0F0, 1, 1, 0, 0,  0, 32'h0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 32'h0,   32'h0,   0, 0, 1, 1,  0, 32'h0,   1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 32'h0,   32'h0,   0, 0, 0, 0,  0, 32'h0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h200, 32'h240, 0, 1, 0, 0,  0, 32'h0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 32'h0,   32'h0,   0, 0, 1, 0,  1, 32'h204, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h300, 32'h310, 1, 1, 0, 0,  0, 32'h0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 32'h0,   32'h0,   0, 0, 0, 0,  0, 32'h0,   0, 0, 0, 0, 0));
    // Fill: full only at the 4th push proves the push during flush was dropped
    tbl.push_back(mk(1, 32'h010, 32'h020, 0, 0, 0, 0,  0, 32'h0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h014, 32'h030, 1, 1, 0, 0,  0, 32'h0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h018, 32'h040, 0, 1, 0, 0,  0, 32'h0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h01C, 32'h050, 1, 0, 0, 0,  0, 32'h0,   0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 32'h020, 32'h060, 1, 1, 0, 0,  0, 32'h0,   0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 32'h024, 32'h060, 0, 0, 1, 0,  0, 32'h0,   1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 32'h0,   32'h0,   0, 0, 1, 1,  0, 32'h0,   1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 32'h0,   32'h0,   0, 0, 1, 1,  0, 32'h0,   1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 32'h0,   32'h0,   0, 0, 1, 0,  0, 32'h0,   1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 32'h0,   32'h0,   0, 0, 1, 0,  0, 32'h0,   1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 32'h0,   32'h0,   0, 0, 0, 0,  0, 32'h0,   0, 0, 0, 0, 0));
    // Three queued, first mispredicts taken: redirect to target, rest discarded
    tbl.push_back(mk(1, 32'h070, 32'h080, 1, 0, 0, 0,  0, 32'h0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h074, 32'h090, 0, 1, 0, 0,  0, 32'h0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h078, 32'h0A0, 0, 1, 0, 0,  0, 32'h0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 32'h0,   32'h0,   0, 0, 1, 1,  1, 32'h080, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 32'h0,   32'h0,   0, 0, 0, 0,  0, 32'h0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 32'h0,   32'h0,   0, 0, 1, 0,  0, 32'h0,   0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 32'h0,   32'h0,   0, 0, 0, 0,  0, 32'h0,   0, 0, 0, 0, 1));

    #2 rst_n = 1'b0;
    #1 chk_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].eu) exp_bc++;
      if (tbl[i].ef) exp_mc++;
      apply(tbl[i], i);
    end

`ifdef BRU_STATS_EN
    chk("BranchCount", 32'(BranchCount), 32'(exp_bc));
    chk("MispredCount", 32'(MispredCount), 32'(exp_mc));
`else
    chk("BranchCount", 32'(BranchCount), 0);
    chk("MispredCount", 32'(MispredCount), 0);
`endif

    // Reset while flushBranch is high (FLUSH state)
    apply(mk(1, 32'h090, 32'h0A0, 0, 1, 0, 0,  0, 32'h0,   0, 0, 0, 0, 1), 100);
    apply(mk(0, 32'h0,   32'h0,   0, 0, 1, 0,  1, 32'h094, 1, 0, 0, 0, 1), 101);
    pulse_reset("rst_flush");
    apply(mk(0, 32'h0,   32'h0,   0, 0, 0, 0,  0, 32'h0,   0, 0, 0, 0, 0), 102);

    // Reset with three entries queued: none may resolve afterwards
    apply(mk(1, 32'h0B0, 32'h0C0, 1, 1, 0, 0,  0, 32'h0,   0, 0, 0, 0, 0), 110);
    apply(mk(1, 32'h0B4, 32'h0C4, 1, 1, 0, 0,  0, 32'h0,   0, 0, 0, 0, 0), 111);
    apply(mk(1, 32'h0B8, 32'h0C8, 1, 1, 0, 0,  0, 32'h0,   0, 0, 0, 0, 0), 112);
    pulse_reset("rst_queued");
    apply(mk(0, 32'h0,   32'h0,   0, 0, 0, 0,  0, 32'h0,   0, 0, 0, 0, 0), 113);
    apply(mk(0, 32'h0,   32'h0,   0, 0, 1, 1,  0, 32'h0,   0, 0, 0, 0, 1), 114);
    apply(mk(0, 32'h0,   32'h0,   0, 0, 0, 0,  0, 32'h0,   0, 0, 0, 0, 1), 115);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
